chip_checker_vector_master: RTL and testbench
=============================================

// Module: chip_checker_vector_master
// PURPOSE
//  Avalon-MM master that runs a chip test from the on-chip vector RAM: per vector it reads one word,
//  drives the DUT pins, waits a settle time, samples and compares the DUT pins, then writes a result word back.
//  Sits between the on-chip memory slave (single-port, no waitrequest, read data valid 1 cycle after address)
//  and the DUT pin drivers. It replaces the CPU for vector playback.
// PARAMETERS
//  PIN_W          16   DUT pin count; vector word = {expected[31:16], drive[15:0]}
//  SETTLE_CYCLES  4    cycles between driving and sampling; must be >=2 to cover the input synchronizer
//  RESULT_OFFSET  128  word offset added to the vector address to form the result address (mod 256)
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  start          in   1   1-cycle pulse; accepted only in IDLE
//  abort          in   1   level; terminates a run
//  base_addr      in   8   word address of vector 0
//  vec_count      in   8   number of vectors, 0..255
//  avm_address    out  8   memory word address
//  avm_chipselect out  1   bus access strobe
//  avm_write      out  1   1 = write, 0 = read (valid with chipselect)
//  avm_byteenable out  4   always 4'hF during a write
//  avm_writedata  out  32  result word {mismatch[15:0], sampled[15:0]}
//  avm_readdata   in   32  memory read data
//  dut_drive      out  16  pattern driven onto the DUT pins
//  dut_oe         out  1   pin driver enable
//  dut_sample     in   16  DUT pins; asynchronous, passed through a 2-flop synchronizer
//  busy           out  1   high from FETCH through WRITE
//  done           out  1   1-cycle pulse at run end (not raised on abort)
//  pass           out  1   1 if no mismatch in the last completed run
//  fail_count     out  8   count of mismatching vectors in the current or last run
//  first_fail_idx out  8   index of the first mismatching vector; valid when fail_count != 0
// BEHAVIOUR
//  Reset: every output and register 0, state IDLE. Both synchronizer stages clear.
//  States: IDLE -> FETCH -> WAIT_DATA -> APPLY -> SAMPLE -> WRITE -> (FETCH | DONE) -> IDLE.
//  IDLE: on start, latch base_addr and vec_count; clear idx, fail_count and first_fail_idx; set pass=0.
//    If vec_count==0, go to DONE. Otherwise go to FETCH. start is ignored in every other state.
//  FETCH (1 cyc): chipselect=1, write=0, address=base+idx (8-bit wrap).
//  WAIT_DATA (1 cyc): chipselect=0; capture avm_readdata into vec_reg.
//  APPLY (SETTLE_CYCLES cyc): dut_drive=vec_reg[15:0], dut_oe=1. A settle counter loads SETTLE_CYCLES-1 on entry
//    and counts down to 0.
//  SAMPLE (1 cyc): sampled = synchronized dut_sample; mismatch = sampled ^ vec_reg[31:16].
//    If mismatch != 0: fail_count += 1; if fail_count was 0, first_fail_idx = idx.
//  WRITE (1 cyc): chipselect=1, write=1, byteenable=4'hF, address=base+idx+RESULT_OFFSET (mod 256),
//    writedata={mismatch, sampled}. Then idx += 1. Go to FETCH if idx+1 < vec_count, else go to DONE.
//  dut_drive and dut_oe hold their values from APPLY through WRITE and into the next FETCH.
//    Both return to 0 in DONE and in IDLE.
//  DONE (1 cyc): done=1; pass=(fail_count==0); busy=0. Next state is IDLE.
//  Timing: start sampled at edge 0 -> first FETCH in cycle 1. Each vector takes 4+SETTLE_CYCLES cycles.
//    done is high in cycle 1+N*(4+SETTLE_CYCLES).
//  Only one bus access per cycle; no read and write ever issued together. No waitrequest exists.
//  abort (any non-IDLE state): the next state is IDLE; chipselect, dut_oe and busy drop the next cycle.
//    No done pulse; pass=0; fail_count and first_fail_idx keep their partial values.
//    A write already issued in the current cycle completes.
//  abort and start in the same IDLE cycle: abort wins, start is ignored.
//  fail_count cannot overflow because vec_count <= 255.
// TESTING  (loopback: dut_sample = dut_drive unless noted; SETTLE_CYCLES=4)
//  Reset asserted mid-run -> all outputs 0 immediately; after release, state IDLE and no bus activity.
//  base=0x10, N=2, mem[0x10]=0x1234_1234, mem[0x11]=0x00FF_00FF -> done at cycle 17, pass=1, fail_count=0,
//    mem[0x90]=0x0000_1234, mem[0x91]=0x0000_00FF.
//  base=0x20, N=1, mem[0x20]=0xFFFF_0F0F -> mem[0xA0]=0xF0F0_0F0F, fail_count=1, first_fail_idx=0, pass=0.
//  vec_count=0 -> done at cycle 1, chipselect never asserted, pass=1.
//  base=0xFF, N=2 -> reads at 0xFF then 0x00; writes at 0x7F then 0x80.
//  abort during APPLY of vector 1 -> IDLE next cycle, dut_oe=0, busy=0, no done; a following start
//    runs normally to completion.

Source files
------------

// File: rtl/chip_checker_vector_master.sv
// Purpose : Avalon-MM master that plays test vectors from on-chip RAM onto DUT pins, compares and writes results.
// Latency : start -> first FETCH next cycle; each vector 4+SETTLE_CYCLES cycles; done pulses in cycle 1+N*(4+SETTLE_CYCLES).
// Backpr. : none; the memory slave has no waitrequest and is assumed to respond in fixed time.
//
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   start, abort                 run control (start pulse taken only in IDLE; abort level ends a run)
//   base_addr, vec_count         word address of vector 0 and number of vectors (0..255)
//   avm_*                        Avalon-MM master to the vector RAM (one access per cycle, fixed read latency 1)
//   dut_drive, dut_oe            pin pattern and pin driver enable
//   dut_sample                   asynchronous DUT pins, synchronized by two flops
//   busy, done, pass             run status; done is a 1-cycle pulse at normal completion only
//   fail_count, first_fail_idx   mismatch statistics of the current or last run
module chip_checker_vector_master #(
  parameter int PIN_W         = 16,   // vector word is {expected, drive}, so this must stay 16
  parameter int SETTLE_CYCLES = 4,    // >= 2 so the synchronizer has caught up before sampling
  parameter int RESULT_OFFSET = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       base_addr,
  input  logic [7:0]       vec_count,
  output logic [7:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write,
  output logic [3:0]       avm_byteenable,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic [PIN_W-1:0] dut_drive,
  output logic             dut_oe,
  input  logic [PIN_W-1:0] dut_sample,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       fail_count,
  output logic [7:0]       first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_APPLY,
    S_SAMPLE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] RES_OFF     = 8'(RESULT_OFFSET);

  state_t           state;
  logic [7:0]       base_q;
  logic [7:0]       count_q;
  logic [7:0]       idx;
  logic [7:0]       settle_cnt;
  logic [PIN_W-1:0] exp_q;       // expected half of the current vector word
  logic [PIN_W-1:0] sync1;
  logic [PIN_W-1:0] sync2;
  logic [PIN_W-1:0] mismatch;
  logic             last_vec;

  assign mismatch = sync2 ^ exp_q;
  // 9-bit compare so idx+1 cannot wrap back below the count
  assign last_vec = ({1'b0, idx} + 9'd1) >= {1'b0, count_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      base_q         <= '0;
      count_q        <= '0;
      idx            <= '0;
      settle_cnt     <= '0;
      exp_q          <= '0;
      sync1          <= '0;
      sync2          <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      dut_drive      <= '0;
      dut_oe         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      sync1 <= dut_sample;
      sync2 <= sync1;
      done  <= 1'b0;

      if (abort && state != S_IDLE) begin
        // A write on the bus this cycle has already been issued and completes; everything drops next cycle.
        state          <= S_IDLE;
        avm_chipselect <= 1'b0;
        avm_write      <= 1'b0;
        avm_byteenable <= '0;
        dut_drive      <= '0;
        dut_oe         <= 1'b0;
        busy           <= 1'b0;
        pass           <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              base_q         <= base_addr;
              count_q        <= vec_count;
              idx            <= '0;
              fail_count     <= '0;
              first_fail_idx <= '0;
              if (vec_count == 8'd0) begin
                // Empty run: no bus traffic, trivially passing.
                state <= S_DONE;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                state          <= S_FETCH;
                pass           <= 1'b0;
                busy           <= 1'b1;
                avm_chipselect <= 1'b1;
                avm_write      <= 1'b0;
                avm_address    <= base_addr;
              end
            end
          end

          S_FETCH: begin
            avm_chipselect <= 1'b0;
            state          <= S_WAIT_DATA;
          end

          S_WAIT_DATA: begin
            // Read data is valid now; drive pins straight from it so APPLY starts with the new pattern.
            exp_q      <= avm_readdata[16 +: PIN_W];
            dut_drive  <= avm_readdata[PIN_W-1:0];
            dut_oe     <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_APPLY;
          end

          S_APPLY: begin
            if (settle_cnt == 8'd0) begin
              state <= S_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt - 8'd1;
            end
          end

          S_SAMPLE: begin
            if (mismatch != '0) begin
              fail_count <= fail_count + 8'd1;
              if (fail_count == 8'd0) begin
                first_fail_idx <= idx;
              end
            end
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_byteenable <= 4'hF;
            avm_address    <= base_q + idx + RES_OFF;
            avm_writedata  <= {mismatch, sync2};
            state          <= S_WRITE;
          end

          S_WRITE: begin
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            idx            <= idx + 8'd1;
            if (!last_vec) begin
              state          <= S_FETCH;
              avm_chipselect <= 1'b1;
              avm_address    <= base_q + idx + 8'd1;
            end else begin
              // fail_count already includes this vector's SAMPLE update.
              state          <= S_DONE;
              avm_chipselect <= 1'b0;
              done           <= 1'b1;
              pass           <= (fail_count == 8'd0);
              busy           <= 1'b0;
              dut_oe         <= 1'b0;
              dut_drive      <= '0;
            end
          end

          S_DONE: begin
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chip_checker_vector_master.sv
// Purpose : self-checking bench for chip_checker_vector_master with a loopback DUT and a behavioural vector RAM.
// Latency : cycle numbers are counted from the edge that samples start (first FETCH is cycle 1).
// Backpr. : none; the RAM model answers reads one cycle after the address and accepts writes immediately.
module tb_chip_checker_vector_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  base_addr;
  logic [7:0]  vec_count;
  logic [7:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic [15:0] dut_drive;
  logic        dut_oe;
  logic [15:0] dut_sample;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  fail_count;
  logic [7:0]  first_fail_idx;

  chip_checker_vector_master #(
    .PIN_W(16),
    .SETTLE_CYCLES(4),
    .RESULT_OFFSET(128)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .base_addr(base_addr),
    .vec_count(vec_count),
    .avm_address(avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write(avm_write),
    .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .dut_drive(dut_drive),
    .dut_oe(dut_oe),
    .dut_sample(dut_sample),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_count(fail_count),
    .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  // Loopback DUT: pins read back exactly what is driven.
  assign dut_sample = dut_drive;

  wire [81:0] all_out = {avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata,
                         dut_drive, dut_oe, busy, done, pass, fail_count, first_fail_idx};

  // Vector RAM: read data valid one cycle after the address.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (avm_chipselect && !avm_write) avm_readdata <= mem[avm_address];
    if (avm_chipselect && avm_write) mem[avm_address] = avm_writedata;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int base_cyc = 0;
  int cs_cnt   = 0;
  int dc;
  bit mon_en   = 1'b0;

  logic [43:0] wr_q[$];        // observed {byteenable, address, writedata}
  logic [39:0] exp_wr_q[$];    // expected {address, writedata}
  logic [7:0]  rd_q[$];
  logic [7:0]  exp_rd_q[$];
  int          done_cyc_q[$];
  logic [43:0] ow;
  logic [39:0] ew;
  logic [7:0]  orr;
  logic [7:0]  err;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (avm_chipselect) begin
        cs_cnt++;
        if (avm_write) wr_q.push_back({avm_byteenable, avm_address, avm_writedata});
        else rd_q.push_back(avm_address);
      end
      if (done) done_cyc_q.push_back(cyc - base_cyc + 1);
    end
  end

  task automatic pulse_start(input logic [7:0] b, input logic [7:0] n);
    @(negedge clk);
    base_addr = b;
    vec_count = n;
    start     = 1'b1;
    mon_en    = 1'b0;
    wr_q.delete();
    rd_q.delete();
    done_cyc_q.delete();
    cs_cnt = 0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    base_cyc = cyc;
    mon_en   = 1'b1;
  endtask

  // Returns the cycle of the first done pulse, or -1 if none within the budget.
  task automatic wait_done(input int budget, output int cyc_of_done);
    cyc_of_done = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cyc_q.size() != 0) begin
        cyc_of_done = done_cyc_q[0];
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (all_out !== 82'd0) $display("FAIL reset_outputs: got %h expected 0", all_out);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    mem[8'h40] = 32'h0000_5555;
    pulse_start(8'h40, 8'd1);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, dut_oe, dut_drive} !== {1'b1, 1'b1, 16'h5555})
      $display("FAIL midrun_apply: got busy/oe/drive %b/%b/%h expected 1/1/5555", busy, dut_oe, dut_drive);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (all_out !== 82'd0) $display("FAIL midrun_reset_outputs: got %h expected 0", all_out);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    cs_cnt  = 0;
    done_cyc_q.delete();
    repeat (10) @(negedge clk);
    n_checks++;
    if (cs_cnt != 0 || done_cyc_q.size() != 0 || busy !== 1'b0)
      $display("FAIL post_reset_idle: got cs_cycles %0d dones %0d busy %b expected 0 0 0",
               cs_cnt, done_cyc_q.size(), busy);
    else n_pass++;
    mon_en = 1'b0;
  endtask

  task automatic test_loopback_pass();
    mem[8'h10] = 32'h1234_1234;
    mem[8'h11] = 32'h00FF_00FF;
    mem[8'h90] = 32'hDEAD_BEEF;
    mem[8'h91] = 32'hDEAD_BEEF;
    pulse_start(8'h10, 8'd2);
    exp_wr_q.delete();
    exp_wr_q.push_back({8'h90, 32'h0000_1234});
    exp_wr_q.push_back({8'h91, 32'h0000_00FF});
    exp_rd_q.delete();
    exp_rd_q.push_back(8'h10);
    exp_rd_q.push_back(8'h11);
    @(negedge clk);
    n_checks++;
    if ({busy, avm_chipselect, avm_write, avm_address} !== {1'b1, 1'b1, 1'b0, 8'h10})
      $display("FAIL pass_fetch: got busy/cs/wr/addr %b/%b/%b/%h expected 1/1/0/10",
               busy, avm_chipselect, avm_write, avm_address);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dut_oe, dut_drive} !== {1'b1, 16'h1234})
      $display("FAIL pass_apply: got oe/drive %b/%h expected 1/1234", dut_oe, dut_drive);
    else n_pass++;
    wait_done(40, dc);
    n_checks++;
    if (dc != 17) $display("FAIL pass_done_cycle: got %0d expected 17", dc);
    else n_pass++;
    n_checks++;
    if ({pass, fail_count, busy} !== {1'b1, 8'd0, 1'b0})
      $display("FAIL pass_status: got pass/fail_count/busy %b/%0d/%b expected 1/0/0", pass, fail_count, busy);
    else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_wr_q.size()) $display("FAIL pass_write_count: got %0d expected %0d", wr_q.size(), exp_wr_q.size());
    else n_pass++;
    while (wr_q.size() != 0 && exp_wr_q.size() != 0) begin
      ow = wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      n_checks++;
      if (ow !== {4'hF, ew}) $display("FAIL pass_write: got be/addr/data %h expected %h", ow, {4'hF, ew});
      else n_pass++;
    end
    n_checks++;
    if (rd_q.size() != exp_rd_q.size()) $display("FAIL pass_read_count: got %0d expected %0d", rd_q.size(), exp_rd_q.size());
    else n_pass++;
    while (rd_q.size() != 0 && exp_rd_q.size() != 0) begin
      orr = rd_q.pop_front();
      err = exp_rd_q.pop_front();
      n_checks++;
      if (orr !== err) $display("FAIL pass_read_addr: got %h expected %h", orr, err);
      else n_pass++;
    end
    n_checks++;
    if ({mem[8'h90], mem[8'h91]} !== {32'h0000_1234, 32'h0000_00FF})
      $display("FAIL pass_mem: got %h %h expected 00001234 000000ff", mem[8'h90], mem[8'h91]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, dut_oe, done, dut_drive, avm_chipselect} !== 20'd0)
      $display("FAIL pass_idle: got busy/oe/done/drive/cs %b/%b/%b/%h/%b expected all 0",
               busy, dut_oe, done, dut_drive, avm_chipselect);
    else n_pass++;
    mon_en = 1'b0;
  endtask

  task automatic test_mismatch();
    mem[8'h20] = 32'hFFFF_0F0F;
    pulse_start(8'h20, 8'd1);
    exp_wr_q.delete();
    exp_wr_q.push_back({8'hA0, 32'hF0F0_0F0F});
    wait_done(30, dc);
    n_checks++;
    if (dc != 9) $display("FAIL mismatch_done_cycle: got %0d expected 9", dc);
    else n_pass++;
    n_checks++;
    if ({pass, fail_count, first_fail_idx} !== {1'b0, 8'd1, 8'd0})
      $display("FAIL mismatch_status: got pass/fail_count/first %b/%0d/%0d expected 0/1/0", pass, fail_count, first_fail_idx);
    else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_wr_q.size()) $display("FAIL mismatch_write_count: got %0d expected %0d", wr_q.size(), exp_wr_q.size());
    else n_pass++;
    while (wr_q.size() != 0 && exp_wr_q.size() != 0) begin
      ow = wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      n_checks++;
      if (ow !== {4'hF, ew}) $display("FAIL mismatch_write: got be/addr/data %h expected %h", ow, {4'hF, ew});
      else n_pass++;
    end
    n_checks++;
    if (mem[8'hA0] !== 32'hF0F0_0F0F) $display("FAIL mismatch_mem: got %h expected f0f00f0f", mem[8'hA0]);
    else n_pass++;
    mon_en = 1'b0;
  endtask

  task automatic test_zero_count();
    pulse_start(8'h50, 8'd0);
    wait_done(10, dc);
    n_checks++;
    if (dc != 1) $display("FAIL zero_done_cycle: got %0d expected 1", dc);
    else n_pass++;
    n_checks++;
    if ({pass, fail_count, busy} !== {1'b1, 8'd0, 1'b0})
      $display("FAIL zero_status: got pass/fail_count/busy %b/%0d/%b expected 1/0/0", pass, fail_count, busy);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (cs_cnt != 0) $display("FAIL zero_no_bus: got %0d chipselect cycles expected 0", cs_cnt);
    else n_pass++;
    mon_en = 1'b0;
  endtask

  task automatic test_addr_wrap();
    mem[8'hFF] = 32'h0000_0000;
    mem[8'h00] = 32'h0000_0003;
    pulse_start(8'hFF, 8'd2);
    exp_wr_q.delete();
    exp_wr_q.push_back({8'h7F, 32'h0000_0000});
    exp_wr_q.push_back({8'h80, 32'h0003_0003});
    exp_rd_q.delete();
    exp_rd_q.push_back(8'hFF);
    exp_rd_q.push_back(8'h00);
    wait_done(40, dc);
    n_checks++;
    if (dc != 17) $display("FAIL wrap_done_cycle: got %0d expected 17", dc);
    else n_pass++;
    n_checks++;
    if ({pass, fail_count, first_fail_idx} !== {1'b0, 8'd1, 8'd1})
      $display("FAIL wrap_status: got pass/fail_count/first %b/%0d/%0d expected 0/1/1", pass, fail_count, first_fail_idx);
    else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_wr_q.size() || rd_q.size() != exp_rd_q.size())
      $display("FAIL wrap_access_count: got writes %0d reads %0d expected 2 2", wr_q.size(), rd_q.size());
    else n_pass++;
    while (wr_q.size() != 0 && exp_wr_q.size() != 0) begin
      ow = wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      n_checks++;
      if (ow !== {4'hF, ew}) $display("FAIL wrap_write: got be/addr/data %h expected %h", ow, {4'hF, ew});
      else n_pass++;
    end
    while (rd_q.size() != 0 && exp_rd_q.size() != 0) begin
      orr = rd_q.pop_front();
      err = exp_rd_q.pop_front();
      n_checks++;
      if (orr !== err) $display("FAIL wrap_read_addr: got %h expected %h", orr, err);
      else n_pass++;
    end
    mon_en = 1'b0;
  endtask

  task automatic test_multi_fail();
    mem[8'h60] = 32'hAAAA_AAAA;
    mem[8'h61] = 32'h0001_0000;
    mem[8'h62] = 32'h8000_0000;
    pulse_start(8'h60, 8'd3);
    exp_wr_q.delete();
    exp_wr_q.push_back({8'hE0, 32'h0000_AAAA});
    exp_wr_q.push_back({8'hE1, 32'h0001_0000});
    exp_wr_q.push_back({8'hE2, 32'h8000_0000});
    wait_done(60, dc);
    n_checks++;
    if (dc != 25) $display("FAIL multi_done_cycle: got %0d expected 25", dc);
    else n_pass++;
    n_checks++;
    if ({pass, fail_count, first_fail_idx} !== {1'b0, 8'd2, 8'd1})
      $display("FAIL multi_status: got pass/fail_count/first %b/%0d/%0d expected 0/2/1", pass, fail_count, first_fail_idx);
    else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_wr_q.size()) $display("FAIL multi_write_count: got %0d expected %0d", wr_q.size(), exp_wr_q.size());
    else n_pass++;
    while (wr_q.size() != 0 && exp_wr_q.size() != 0) begin
      ow = wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      n_checks++;
      if (ow !== {4'hF, ew}) $display("FAIL multi_write: got be/addr/data %h expected %h", ow, {4'hF, ew});
      else n_pass++;
    end
    mon_en = 1'b0;
  endtask

  task automatic test_abort();
    mem[8'h30] = 32'h0005_0000;
    mem[8'h31] = 32'h1111_1111;
    mem[8'h32] = 32'h2222_2222;
    pulse_start(8'h30, 8'd3);
    exp_wr_q.delete();
    exp_wr_q.push_back({8'hB0, 32'h0005_0000});
    repeat (11) @(negedge clk);
    n_checks++;
    if ({busy, dut_oe, dut_drive} !== {1'b1, 1'b1, 16'h1111})
      $display("FAIL abort_apply: got busy/oe/drive %b/%b/%h expected 1/1/1111", busy, dut_oe, dut_drive);
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, dut_oe, avm_chipselect, dut_drive} !== 19'd0)
      $display("FAIL abort_drop: got busy/oe/cs/drive %b/%b/%b/%h expected all 0", busy, dut_oe, avm_chipselect, dut_drive);
    else n_pass++;
    abort = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_cyc_q.size() != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cyc_q.size());
    else n_pass++;
    n_checks++;
    if ({pass, fail_count, first_fail_idx} !== {1'b0, 8'd1, 8'd0})
      $display("FAIL abort_partial: got pass/fail_count/first %b/%0d/%0d expected 0/1/0", pass, fail_count, first_fail_idx);
    else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_wr_q.size()) $display("FAIL abort_write_count: got %0d expected %0d", wr_q.size(), exp_wr_q.size());
    else n_pass++;
    while (wr_q.size() != 0 && exp_wr_q.size() != 0) begin
      ow = wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      n_checks++;
      if (ow !== {4'hF, ew}) $display("FAIL abort_write: got be/addr/data %h expected %h", ow, {4'hF, ew});
      else n_pass++;
    end

    mem[8'h30] = 32'h0005_0005;
    pulse_start(8'h30, 8'd3);
    exp_wr_q.delete();
    exp_wr_q.push_back({8'hB0, 32'h0000_0005});
    exp_wr_q.push_back({8'hB1, 32'h0000_1111});
    exp_wr_q.push_back({8'hB2, 32'h0000_2222});
    wait_done(60, dc);
    n_checks++;
    if (dc != 25) $display("FAIL rerun_done_cycle: got %0d expected 25", dc);
    else n_pass++;
    n_checks++;
    if ({pass, fail_count} !== {1'b1, 8'd0})
      $display("FAIL rerun_status: got pass/fail_count %b/%0d expected 1/0", pass, fail_count);
    else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_wr_q.size()) $display("FAIL rerun_write_count: got %0d expected %0d", wr_q.size(), exp_wr_q.size());
    else n_pass++;
    while (wr_q.size() != 0 && exp_wr_q.size() != 0) begin
      ow = wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      n_checks++;
      if (ow !== {4'hF, ew}) $display("FAIL rerun_write: got be/addr/data %h expected %h", ow, {4'hF, ew});
      else n_pass++;
    end
    mon_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    // abort and start together in IDLE: abort wins
    @(negedge clk);
    base_addr = 8'h10;
    vec_count = 8'd2;
    start     = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if ({busy, avm_chipselect} !== 2'b00)
      $display("FAIL abort_start_idle: got busy/cs %b/%b expected 0/0", busy, avm_chipselect);
    else n_pass++;

    // start pulse mid-run is ignored
    pulse_start(8'h10, 8'd2);
    exp_wr_q.delete();
    exp_wr_q.push_back({8'h90, 32'h0000_1234});
    exp_wr_q.push_back({8'h91, 32'h0000_00FF});
    repeat (4) @(negedge clk);
    base_addr = 8'h20;
    vec_count = 8'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, dc);
    n_checks++;
    if (dc != 17) $display("FAIL b2b_first_done_cycle: got %0d expected 17", dc);
    else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_wr_q.size()) $display("FAIL b2b_first_write_count: got %0d expected %0d", wr_q.size(), exp_wr_q.size());
    else n_pass++;
    while (wr_q.size() != 0 && exp_wr_q.size() != 0) begin
      ow = wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      n_checks++;
      if (ow !== {4'hF, ew}) $display("FAIL b2b_first_write: got be/addr/data %h expected %h", ow, {4'hF, ew});
      else n_pass++;
    end

    // next run starts in the first IDLE cycle after DONE
    pulse_start(8'h20, 8'd1);
    exp_wr_q.delete();
    exp_wr_q.push_back({8'hA0, 32'hF0F0_0F0F});
    wait_done(30, dc);
    n_checks++;
    if (dc != 9) $display("FAIL b2b_second_done_cycle: got %0d expected 9", dc);
    else n_pass++;
    n_checks++;
    if ({pass, fail_count, first_fail_idx} !== {1'b0, 8'd1, 8'd0})
      $display("FAIL b2b_second_status: got pass/fail_count/first %b/%0d/%0d expected 0/1/0", pass, fail_count, first_fail_idx);
    else n_pass++;
    while (wr_q.size() != 0 && exp_wr_q.size() != 0) begin
      ow = wr_q.pop_front();
      ew = exp_wr_q.pop_front();
      n_checks++;
      if (ow !== {4'hF, ew}) $display("FAIL b2b_second_write: got be/addr/data %h expected %h", ow, {4'hF, ew});
      else n_pass++;
    end
    mon_en = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = 8'h00;
    vec_count = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_loopback_pass();
    test_mismatch();
    test_zero_count();
    test_addr_wrap();
    test_multi_fail();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
